matmul_sequencer: RTL and testbench

- Controller that sequences the 2x2 8-bit matrix_multiply datapath.
- Accepts a stream of 8 operand bytes over a valid/ready handshake and writes each byte into the datapath's A/B registers by driving sel_in, input_val and execute.
- Then streams the four 17-bit products C00, C01, C10, C11 out over a valid/ready handshake.
- Sits between the user_proj_example pad/LA glue and the matrix_multiply instance, replacing direct pad control of the datapath.

---
 rtl/matmul_pkg.sv | 16 +
 rtl/matmul_sequencer.sv | 131 +++++++++++++
 tb/tb_matmul_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state type and sizing constants for the matmul sequencer
package matmul_pkg;

  // Controller phases: collect operands, capture first product, stream products out
  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    DRAIN  = 2'd2
  } mm_state_t;

  localparam int NUM_OPERANDS = 8;
  localparam int NUM_RESULTS  = 4;
  localparam int MM_DATA_W    = 8;
  localparam int MM_RES_W     = 2 * MM_DATA_W + 1;

endpackage

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - streams 8 operand bytes into the 2x2 matrix_multiply datapath and 4 products out
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_W = MM_DATA_W,
  parameter int RES_W  = 2 * DATA_W + 1,
  parameter int CNT_W  = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic [2:0]        mm_sel_in,
  output logic [DATA_W-1:0] mm_input_val,
  output logic              mm_execute,
  output logic [1:0]        mm_sel_out,
  input  logic [RES_W-1:0]  mm_result,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [2:0] LAST_LD  = 3'(NUM_OPERANDS - 1);
  localparam logic [1:0] LAST_RES = 2'(NUM_RESULTS - 1);

  mm_state_t  state;
  mm_state_t  state_nxt;
  logic [2:0] ld_cnt;
  logic [1:0] rd_ptr;
  logic       in_hs;
  logic       out_hs;
  logic       last_hs;

  assign in_hs   = in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;
  assign last_hs = out_hs && (out_idx == LAST_RES);

  // The datapath writes whenever execute is low, so only an accepted byte may drop it
  assign mm_execute   = !in_hs;
  assign mm_sel_in    = ld_cnt;
  assign mm_input_val = in_data;
  assign out_last     = out_valid && (out_idx == LAST_RES);
  assign busy         = (state != LOAD) || (ld_cnt != 3'd0);

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= LOAD;
    else          state <= state_nxt;
  end

  // Next-state: abort always returns to LOAD
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (in_hs && (ld_cnt == LAST_LD)) state_nxt = SETTLE;
        SETTLE:  state_nxt = DRAIN;
        DRAIN:   if (last_hs) state_nxt = LOAD;
        default: state_nxt = LOAD;
      endcase
    end
  end

  // Handshake and read-select outputs; in_ready is held low during reset and abort so nothing is written
  always_comb begin
    in_ready   = 1'b0;
    mm_sel_out = 2'd0;
    case (state)
      LOAD:    in_ready = !wb_rst_i && !abort;
      SETTLE:  mm_sel_out = 2'd0;
      DRAIN:   mm_sel_out = rd_ptr;
      default: ;
    endcase
  end

  // Operand counter, result pointer, registered result stream and operation counter
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ld_cnt    <= 3'd0;
      rd_ptr    <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= 2'd0;
      done      <= 1'b0;
      op_count  <= '0;
    end else if (abort) begin
      ld_cnt    <= 3'd0;
      rd_ptr    <= 2'd0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          if (in_hs) ld_cnt <= (ld_cnt == LAST_LD) ? 3'd0 : ld_cnt + 3'd1;
        end
        SETTLE: begin
          out_data  <= mm_result;
          out_idx   <= 2'd0;
          out_valid <= 1'b1;
          rd_ptr    <= 2'd1;
        end
        DRAIN: begin
          if (out_hs) begin
            if (out_idx != LAST_RES) begin
              out_data <= mm_result;
              out_idx  <= rd_ptr;
              rd_ptr   <= rd_ptr + 2'd1;
            end else begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              op_count  <= op_count + CNT_W'(1);
              rd_ptr    <= 2'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - self-checking bench for matmul_sequencer with a stand-in datapath
module tb_matmul_sequencer;

  typedef logic [7:0][7:0]  ops_t;
  typedef logic [3:0][16:0] res_t;
  typedef struct packed {
    ops_t       ops;
    res_t       res;
    logic [1:0] gaps;
    logic       stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic [2:0]  mm_sel_in;
  logic [7:0]  mm_input_val;
  logic        mm_execute;
  logic [1:0]  mm_sel_out;
  logic [16:0] mm_result;
  logic        busy;
  logic        done;
  logic [15:0] op_count;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  bit mon_en      = 0;

  always #5 clk = ~clk;

  matmul_sequencer #(.DATA_W(8), .RES_W(17), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last),
    .mm_sel_in(mm_sel_in), .mm_input_val(mm_input_val), .mm_execute(mm_execute),
    .mm_sel_out(mm_sel_out), .mm_result(mm_result),
    .busy(busy), .done(done), .op_count(op_count)
  );

  // Stand-in matrix_multiply: 8 element registers written while execute is low
  logic [7:0] elem [8];
  initial for (int k = 0; k < 8; k++) elem[k] = 8'd0;
  always @(posedge clk) if (!mm_execute) elem[mm_sel_in] <= mm_input_val;
  always_comb begin
    case (mm_sel_out)
      2'd0:    mm_result = elem[0] * elem[4] + elem[1] * elem[6];
      2'd1:    mm_result = elem[0] * elem[5] + elem[1] * elem[7];
      2'd2:    mm_result = elem[2] * elem[4] + elem[3] * elem[6];
      default: mm_result = elem[2] * elem[5] + elem[3] * elem[7];
    endcase
  end

  // Reference: C = A x B, A row-major from bytes 0..3, B row-major from bytes 4..7
  function automatic logic [16:0] ref_c(input ops_t o, input int idx);
    int r = idx / 2;
    int c = idx % 2;
    int s = 0;
    for (int k = 0; k < 2; k++) s += int'(o[2*r+k]) * int'(o[4+2*k+c]);
    return 17'(s);
  endfunction

  function automatic ops_t pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    ops_t o;
    o[0] = 8'(a0); o[1] = 8'(a1); o[2] = 8'(a2); o[3] = 8'(a3);
    o[4] = 8'(a4); o[5] = 8'(a5); o[6] = 8'(a6); o[7] = 8'(a7);
    return o;
  endfunction

  function automatic res_t res4(input int c0, c1, c2, c3);
    res_t r;
    r[0] = 17'(c0); r[1] = 17'(c1); r[2] = 17'(c2); r[3] = 17'(c3);
    return r;
  endfunction

  function automatic vec_t mkvec(input ops_t o, input res_t r, input logic [1:0] g, input logic s);
    vec_t v;
    v.ops = o; v.res = r; v.gaps = g; v.stall = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle invariants: write protection, no intake while draining, stable stalled output
  logic        p_stall = 1'b0;
  logic        p_ctl   = 1'b0;
  logic [16:0] p_data  = '0;
  logic [1:0]  p_idx   = '0;
  initial forever begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      chk("mm_execute", mm_execute, !(in_valid && in_ready));
      if (out_valid) chk("in_ready_drain", in_ready, 0);
      if (p_stall && !p_ctl) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, p_data);
        chk("stall_idx", out_idx, p_idx);
      end
    end
    if (done) done_cnt++;
    p_stall = out_valid && !out_ready;
    p_ctl   = abort || rst;
    p_data  = out_data;
    p_idx   = out_idx;
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 0; in_data = 8'($urandom); out_ready = 0; abort = 0;
      #1;
    end
  endtask

  // gaps: 0 none, 1 alternate valid/idle, 2 random idles
  task automatic send(input ops_t o, input int n, input int gaps);
    int i = 0;
    int guard = 0;
    bit hole = 0;
    while (i < n && guard < 100) begin
      @(negedge clk);
      abort = 0; out_ready = 0;
      if (hole) begin in_valid = 0; in_data = 8'($urandom); end
      else      begin in_valid = 1; in_data = o[i]; end
      #1;
      if (in_valid && in_ready) i++;
      if (gaps == 1)      hole = !hole;
      else if (gaps == 2) hole = 1'($urandom_range(0, 1));
      guard++;
    end
    chk("send_count", i, n);
  endtask

  task automatic recv(input res_t exp, input int n, input bit stall, input bit chk_lat);
    int got = 0;
    int cyc = 0;
    int first = -1;
    int left = 3;
    int guard = 0;
    while (got < n && guard < 60) begin
      @(negedge clk);
      in_valid = 0; in_data = 8'($urandom); abort = 0;
      cyc++;
      out_ready = !(stall && out_valid && got == 2 && left > 0);
      if (!out_ready) left--;
      #1;
      if (out_valid && first < 0) first = cyc;
      if (out_valid && out_ready) begin
        chk("res_data", out_data, exp[got]);
        chk("res_idx", out_idx, got);
        chk("res_last", out_last, got == 3);
        got++;
      end
      guard++;
    end
    chk("recv_count", got, n);
    if (chk_lat) chk("first_valid_latency", first, 2);
  endtask

  task automatic run_vec(input vec_t v);
    int d0 = done_cnt;
    logic [15:0] c0 = op_count;
    send(v.ops, 8, int'(v.gaps));
    recv(v.res, 4, v.stall, v.gaps == 2'd0);
    idle(2);
    chk("op_count", op_count, c0 + 16'd1);
    chk("done_pulses", done_cnt - d0, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  vec_t tbl [5];

  initial begin
    int d0;
    logic [15:0] c0;
    ops_t ro;
    res_t rr;

    tbl[0] = mkvec(pack8(1, 2, 3, 4, 5, 6, 7, 8), res4(19, 22, 43, 50), 2'd0, 1'b0);
    tbl[1] = mkvec(pack8(255, 255, 255, 255, 255, 255, 255, 255),
                   res4(130050, 130050, 130050, 130050), 2'd0, 1'b0);
    tbl[2] = mkvec(pack8(2, 0, 0, 2, 1, 1, 1, 1), res4(2, 2, 2, 2), 2'd0, 1'b1);
    tbl[3] = mkvec(pack8(1, 2, 3, 4, 5, 6, 7, 8), res4(19, 22, 43, 50), 2'd1, 1'b1);
    tbl[4] = mkvec(pack8(0, 0, 0, 0, 9, 9, 9, 9), res4(0, 0, 0, 0), 2'd1, 1'b0);

    rst = 1; abort = 0; in_valid = 1; in_data = 8'hA5; out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_execute", mm_execute, 1);
    @(negedge clk);
    rst = 0; in_valid = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_last", out_last, 0);
    mon_en = 1;

    for (int t = 0; t < 5; t++) run_vec(tbl[t]);

    // Long idle with junk on in_data must not disturb the datapath
    for (int k = 0; k < 20; k++) begin
      idle(1);
      chk("idle_execute", mm_execute, 1);
    end
    run_vec(tbl[0]);

    // Randomized operands against the reference model
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 8; k++) ro[k] = 8'($urandom);
      for (int j = 0; j < 4; j++) rr[j] = ref_c(ro, j);
      run_vec(mkvec(ro, rr, 2'd2, 1'($urandom_range(0, 1))));
    end

    // Abort after five bytes
    d0 = done_cnt; c0 = op_count;
    send(pack8(9, 9, 9, 9, 9, 9, 9, 9), 5, 0);
    chk("partial_busy", busy, 1);
    @(negedge clk);
    abort = 1; in_valid = 1; in_data = 8'hEE;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_execute", mm_execute, 1);
    idle(2);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_op_count", op_count, c0);
    run_vec(tbl[2]);

    // Abort in DRAIN after two results
    d0 = done_cnt; c0 = op_count;
    send(tbl[0].ops, 8, 0);
    recv(tbl[0].res, 2, 1'b0, 1'b0);
    @(negedge clk);
    abort = 1; out_ready = 0;
    #1;
    @(negedge clk);
    abort = 0;
    #1;
    chk("drain_abort_valid", out_valid, 0);
    chk("drain_abort_in_ready", in_ready, 1);
    chk("drain_abort_op_count", op_count, c0);
    idle(2);
    chk("drain_abort_no_done", done_cnt - d0, 0);
    run_vec(tbl[3]);

    // Reset mid-drain, then reset during a partial load
    send(tbl[0].ops, 8, 0);
    recv(tbl[0].res, 1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1; out_ready = 0;
    #1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_op_count", op_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_data", out_data, 0);
    send(pack8(7, 7, 7, 7, 7, 7, 7, 7), 3, 0);
    chk("part_busy", busy, 1);
    @(negedge clk);
    rst = 1; in_valid = 0;
    #1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("part_rst_busy", busy, 0);
    for (int k = 0; k < 8; k++) ro[k] = 8'($urandom);
    for (int j = 0; j < 4; j++) rr[j] = ref_c(ro, j);
    run_vec(mkvec(ro, rr, 2'd0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
